i2si_bist_ctrl: RTL and testbench

//   Sequencer/checker for the I2S-input BIST saw-tooth generator. On a go pulse it snapshots the

---
 rtl/i2si_bist_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_i2si_bist_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2si_bist_ctrl.sv
// -----------------------------------------------------------------------------
// i2si_bist_ctrl
//
// Sequencer and checker for the I2S-input BIST saw-tooth generator.
// A go pulse snapshots the BIST configuration, holds the generator in reset for
// two clocks, then releases it and gates sck_transition through to it. Every
// looped-back word is compared against a local saw-tooth model until
// rf_bist_len words have been seen. Status: busy, sticky done/pass/timeout, a
// saturating mismatch count and the first mismatching word.
//
// Handshake: rx_xfc is a one-clock strobe qualifying rx_data. There is no
// backpressure; a word is consumed on every clock rx_xfc is high while the
// FSM is in RUN and ignored in every other state.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   sck_transition       one-clock serial clock pulse from the I2S front end
//   rf_bist_go/abort     one-clock start / abort pulses (abort wins)
//   rf_bist_start_val    saw-tooth start value
//   rf_bist_inc          saw-tooth increment (zero-extended)
//   rf_bist_up_limit     saw-tooth upper limit (unsigned)
//   rf_bist_len          number of words to check (0 = immediate pass)
//   rx_data, rx_xfc      looped-back word and its valid strobe
//   gen_rst_n            registered generator reset, low = held
//   gen_sck_transition   sck_transition gated by RUN
//   gen_start_val/inc/up_limit  configuration snapshot driven to the generator
//   bist_busy            high in ARM or RUN
//   bist_done/pass/timeout  sticky status, cleared by the next accepted go
//   bist_err_cnt         saturating mismatch count
//   bist_first_err_data  rx_data of the first mismatch
//   bist_state           current FSM state (IDLE=0, ARM=1, RUN=2, DONE=3)
// -----------------------------------------------------------------------------
module i2si_bist_ctrl #(
    parameter int DATA_W  = 32,
    parameter int INC_W   = 8,
    parameter int CNT_W   = 16,
    parameter int TMO_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sck_transition,
    input  logic              rf_bist_go,
    input  logic              rf_bist_abort,
    input  logic [DATA_W-1:0] rf_bist_start_val,
    input  logic [INC_W-1:0]  rf_bist_inc,
    input  logic [DATA_W-1:0] rf_bist_up_limit,
    input  logic [CNT_W-1:0]  rf_bist_len,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_xfc,
    output logic              gen_rst_n,
    output logic              gen_sck_transition,
    output logic [DATA_W-1:0] gen_start_val,
    output logic [INC_W-1:0]  gen_inc,
    output logic [DATA_W-1:0] gen_up_limit,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_pass,
    output logic              bist_timeout,
    output logic [CNT_W-1:0]  bist_err_cnt,
    output logic [DATA_W-1:0] bist_first_err_data,
    output logic [1:0]        bist_state
);

    // Wide enough to hold TMO_CYC-1.
    localparam int TMO_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              arm_cnt_q;
    logic              gen_rst_n_q;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  word_cnt_q;
    logic [CNT_W-1:0]  err_cnt_q;
    logic [DATA_W-1:0] exp_val_q;
    logic [DATA_W-1:0] first_err_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic              done_q, pass_q, timeout_q;

    // Decoded control events for the datapath
    logic              accept_go, do_abort, word_acc, last_word, tmo_hit;
    logic              mismatch;
    logic [CNT_W-1:0]  word_cnt_inc;
    logic [CNT_W-1:0]  err_cnt_nxt;
    logic [DATA_W-1:0] exp_nxt;

    assign word_cnt_inc = word_cnt_q + CNT_W'(1);
    assign mismatch     = word_acc && (rx_data != exp_val_q);
    assign err_cnt_nxt  = (mismatch && (err_cnt_q != '1)) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
    // Unsigned compare, modulo-2^DATA_W add: a start near the top wraps through zero.
    assign exp_nxt      = (exp_val_q >= gen_up_limit) ? gen_start_val
                                                      : exp_val_q + DATA_W'(gen_inc);

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept_go = 1'b0;
        do_abort  = 1'b0;
        word_acc  = 1'b0;
        last_word = 1'b0;
        tmo_hit   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (rf_bist_go && !rf_bist_abort) begin
                    accept_go = 1'b1;
                    state_d   = (rf_bist_len == '0) ? S_DONE : S_ARM;
                end
            end
            S_ARM: begin
                if (rf_bist_abort) begin
                    do_abort = 1'b1;
                    state_d  = S_IDLE;
                end else if (arm_cnt_q) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (rf_bist_abort) begin
                    do_abort = 1'b1;
                    state_d  = S_IDLE;
                end else if (rx_xfc) begin
                    // A word on the threshold cycle beats the timeout.
                    word_acc = 1'b1;
                    if (word_cnt_inc == len_q) begin
                        last_word = 1'b1;
                        state_d   = S_DONE;
                    end
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_hit = 1'b1;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequencing: ARM lasts two clocks; generator reset released on RUN entry
    // and reasserted on the clock RUN is left.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt_q   <= 1'b0;
            gen_rst_n_q <= 1'b0;
            tmo_cnt_q   <= '0;
        end else begin
            arm_cnt_q   <= (state_q == S_ARM) && (state_d == S_ARM);
            gen_rst_n_q <= (state_d == S_RUN);
            if ((state_q == S_RUN) && (state_d == S_RUN) && !rx_xfc) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end else begin
                tmo_cnt_q <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Snapshot, model and status datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_start_val <= '0;
            gen_inc       <= '0;
            gen_up_limit  <= '0;
            len_q         <= '0;
            exp_val_q     <= '0;
            word_cnt_q    <= '0;
            err_cnt_q     <= '0;
            first_err_q   <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            if (accept_go) begin
                gen_start_val <= rf_bist_start_val;
                gen_inc       <= rf_bist_inc;
                gen_up_limit  <= rf_bist_up_limit;
                len_q         <= rf_bist_len;
                exp_val_q     <= rf_bist_start_val;
                word_cnt_q    <= '0;
                err_cnt_q     <= '0;
                first_err_q   <= '0;
                timeout_q     <= 1'b0;
                // Zero-length run completes immediately with a pass.
                done_q        <= (rf_bist_len == '0);
                pass_q        <= (rf_bist_len == '0);
            end
            if (do_abort) begin
                // err_cnt / first_err are left intact for post-mortem.
                done_q <= 1'b0;
                pass_q <= 1'b0;
            end
            if (word_acc) begin
                exp_val_q  <= exp_nxt;
                word_cnt_q <= word_cnt_inc;
                err_cnt_q  <= err_cnt_nxt;
                if (mismatch && (err_cnt_q == '0)) begin
                    first_err_q <= rx_data;
                end
                if (last_word) begin
                    done_q <= 1'b1;
                    pass_q <= (err_cnt_nxt == '0);
                end
            end
            if (tmo_hit) begin
                done_q    <= 1'b1;
                pass_q    <= 1'b0;
                timeout_q <= 1'b1;
            end
        end
    end

    assign gen_rst_n           = gen_rst_n_q;
    assign gen_sck_transition  = sck_transition & (state_q == S_RUN);
    assign bist_busy           = (state_q == S_ARM) || (state_q == S_RUN);
    assign bist_done           = done_q;
    assign bist_pass           = pass_q;
    assign bist_timeout        = timeout_q;
    assign bist_err_cnt        = err_cnt_q;
    assign bist_first_err_data = first_err_q;
    assign bist_state          = state_q;

endmodule

// File: tb/tb_i2si_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_i2si_bist_ctrl
//
// Drives BIST runs into i2si_bist_ctrl with a behavioural saw-tooth generator
// looping words back on rx_data/rx_xfc. Each accepted run pushes its expected
// final status into exp_q; a monitor pops and compares whenever bist_done
// rises. Directed cases cover reset, abort, go/abort collision, zero length
// and timeout; a loop adds randomized configurations and corruptions.
// -----------------------------------------------------------------------------
module tb_i2si_bist_ctrl;

    localparam int DATA_W  = 32;
    localparam int INC_W   = 8;
    localparam int CNT_W   = 16;
    localparam int TMO_CYC = 64;
    localparam int RES_W   = 2 + CNT_W + DATA_W;   // {timeout, pass, err_cnt, first_err}
    localparam int PULSES_PER_WORD = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic              sck_transition = 1'b0;
    logic              rf_bist_go;
    logic              rf_bist_abort;
    logic [DATA_W-1:0] rf_bist_start_val;
    logic [INC_W-1:0]  rf_bist_inc;
    logic [DATA_W-1:0] rf_bist_up_limit;
    logic [CNT_W-1:0]  rf_bist_len;
    logic [DATA_W-1:0] rx_data = '0;
    logic              rx_xfc = 1'b0;
    logic              gen_rst_n;
    logic              gen_sck_transition;
    logic [DATA_W-1:0] gen_start_val;
    logic [INC_W-1:0]  gen_inc;
    logic [DATA_W-1:0] gen_up_limit;
    logic              bist_busy;
    logic              bist_done;
    logic              bist_pass;
    logic              bist_timeout;
    logic [CNT_W-1:0]  bist_err_cnt;
    logic [DATA_W-1:0] bist_first_err_data;
    logic [1:0]        bist_state;

    i2si_bist_ctrl #(
        .DATA_W (DATA_W),
        .INC_W  (INC_W),
        .CNT_W  (CNT_W),
        .TMO_CYC(TMO_CYC)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .sck_transition     (sck_transition),
        .rf_bist_go         (rf_bist_go),
        .rf_bist_abort      (rf_bist_abort),
        .rf_bist_start_val  (rf_bist_start_val),
        .rf_bist_inc        (rf_bist_inc),
        .rf_bist_up_limit   (rf_bist_up_limit),
        .rf_bist_len        (rf_bist_len),
        .rx_data            (rx_data),
        .rx_xfc             (rx_xfc),
        .gen_rst_n          (gen_rst_n),
        .gen_sck_transition (gen_sck_transition),
        .gen_start_val      (gen_start_val),
        .gen_inc            (gen_inc),
        .gen_up_limit       (gen_up_limit),
        .bist_busy          (bist_busy),
        .bist_done          (bist_done),
        .bist_pass          (bist_pass),
        .bist_timeout       (bist_timeout),
        .bist_err_cnt       (bist_err_cnt),
        .bist_first_err_data(bist_first_err_data),
        .bist_state         (bist_state)
    );

    // ---------------- scoreboard state ----------------
    logic [RES_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Saw-tooth rule: reload at or above the limit, otherwise add (wrapping).
    function automatic logic [DATA_W-1:0] saw_next(input logic [DATA_W-1:0] v,
                                                   input logic [DATA_W-1:0] s,
                                                   input logic [INC_W-1:0]  inc,
                                                   input logic [DATA_W-1:0] up);
        if (v >= up) return s;
        return v + {{(DATA_W-INC_W){1'b0}}, inc};
    endfunction

    // Expected final status of a completed run: walk the sequence, apply the
    // planted corruptions, count differences.
    function automatic logic [RES_W-1:0] model(input logic [DATA_W-1:0] s,
                                               input logic [INC_W-1:0]  inc,
                                               input logic [DATA_W-1:0] up,
                                               input int len,
                                               input int c0, input logic [DATA_W-1:0] v0,
                                               input int c1, input logic [DATA_W-1:0] v1);
        logic [DATA_W-1:0] v;
        logic [DATA_W-1:0] got;
        logic [DATA_W-1:0] first;
        int errs;
        v = s; first = '0; errs = 0;
        for (int i = 0; i < len; i++) begin
            got = (i == c0) ? v0 : (i == c1) ? v1 : v;
            if (got != v) begin
                if (errs == 0) first = got;
                errs++;
            end
            v = saw_next(v, s, inc, up);
        end
        return {1'b0, (errs == 0), CNT_W'(errs), first};
    endfunction

    // ---------------- loopback generator ----------------
    int                g_idx = 0;
    int                g_pulses = 0;
    logic [DATA_W-1:0] g_val = '0;
    int                c_idx0 = -1, c_idx1 = -1;
    logic [DATA_W-1:0] c_val0 = '0, c_val1 = '0;
    int                word_limit = 1 << 30;
    logic              inj_req = 1'b0;
    logic              sck_en = 1'b0;
    logic              sck_force = 1'b0;
    logic              s_sck = 1'b0, s_rst = 1'b0;

    always @(negedge clk) begin
        s_sck = gen_sck_transition;
        s_rst = gen_rst_n;
    end

    always @(posedge clk) begin
        #1;
        rx_xfc = 1'b0;
        if (!s_rst) begin
            g_val    = gen_start_val;
            g_idx    = 0;
            g_pulses = 0;
            if (inj_req) begin
                // Stray word while the controller is not in RUN.
                rx_xfc  = 1'b1;
                rx_data = ~gen_start_val;
            end
        end else if (s_sck) begin
            g_pulses++;
            if (g_pulses == PULSES_PER_WORD) begin
                g_pulses = 0;
                rx_xfc   = 1'b1;
                if (g_idx == c_idx0)      rx_data = c_val0;
                else if (g_idx == c_idx1) rx_data = c_val1;
                else                      rx_data = g_val;
                g_val = saw_next(g_val, gen_start_val, gen_inc, gen_up_limit);
                g_idx++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        sck_transition = sck_force | (sck_en && (g_idx < word_limit) && ($urandom_range(0, 3) != 0));
    end

    // ---------------- monitor ----------------
    logic done_prev = 1'b0;
    int   neg_cyc = 0;
    int   last_xfc_cyc = 0;

    always @(negedge clk) begin
        logic [RES_W-1:0] r;
        neg_cyc++;
        if (rx_xfc) last_xfc_cyc = neg_cyc;
        if (rst_n && bist_done && !done_prev) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: done rose with no run pending");
            end else begin
                r = exp_q.pop_front();
                check("timeout",   64'(bist_timeout),        64'(r[RES_W-1]));
                check("pass",      64'(bist_pass),           64'(r[RES_W-2]));
                check("err_cnt",   64'(bist_err_cnt),        64'(r[DATA_W +: CNT_W]));
                check("first_err", 64'(bist_first_err_data), 64'(r[DATA_W-1:0]));
                check("busy_at_done",  64'(bist_busy), 64'd0);
                check("gen_rst_at_done", 64'(gen_rst_n), 64'd0);
                if (r[RES_W-1]) begin
                    check("tmo_latency", 64'(neg_cyc - last_xfc_cyc), 64'(TMO_CYC + 1));
                end
            end
        end
        done_prev = bist_done;
    end

    // ---------------- driver tasks ----------------
    task automatic scramble_rf();
        rf_bist_start_val = $urandom;
        rf_bist_inc       = INC_W'($urandom);
        rf_bist_up_limit  = $urandom;
        rf_bist_len       = CNT_W'($urandom_range(0, 50));
    endtask

    task automatic pulse_go(input logic [DATA_W-1:0] s, input logic [INC_W-1:0] inc,
                            input logic [DATA_W-1:0] up, input logic [CNT_W-1:0] len,
                            input bit inj, input bit with_abort);
        @(negedge clk);
        rf_bist_start_val = s;
        rf_bist_inc       = inc;
        rf_bist_up_limit  = up;
        rf_bist_len       = len;
        rf_bist_go        = 1'b1;
        rf_bist_abort     = with_abort;
        inj_req           = inj;
        @(negedge clk);
        rf_bist_go    = 1'b0;
        rf_bist_abort = 1'b0;
        inj_req       = 1'b0;
        scramble_rf();
    endtask

    task automatic pulse_abort();
        @(negedge clk);
        rf_bist_abort = 1'b1;
        @(negedge clk);
        rf_bist_abort = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL %s: done not seen within %0d cycles, %0d result(s) pending",
                     name, n, exp_q.size());
            exp_q.delete();
            pulse_abort();
        end
        sck_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic run_test(input string name,
                            input logic [DATA_W-1:0] s, input logic [INC_W-1:0] inc,
                            input logic [DATA_W-1:0] up, input logic [CNT_W-1:0] len,
                            input int c0, input logic [DATA_W-1:0] v0,
                            input int c1, input logic [DATA_W-1:0] v1,
                            input bit inj, input bit busy_go, input bit tmo);
        c_idx0 = c0; c_val0 = v0;
        c_idx1 = c1; c_val1 = v1;
        word_limit = tmo ? 2 : (1 << 30);
        if (tmo) exp_q.push_back({1'b1, 1'b0, CNT_W'(0), DATA_W'(0)});
        else     exp_q.push_back(model(s, inc, up, int'(len), c0, v0, c1, v1));
        sck_en = 1'b1;
        pulse_go(s, inc, up, len, inj, 1'b0);
        if (busy_go) begin
            repeat ($urandom_range(2, 8)) @(negedge clk);
            if (bist_busy) begin
                // Ignored: controller is busy.
                rf_bist_start_val = $urandom;
                rf_bist_len       = CNT_W'($urandom_range(1, 5));
                rf_bist_go        = 1'b1;
                @(negedge clk);
                rf_bist_go = 1'b0;
            end
        end
        wait_drain(name);
        word_limit = 1 << 30;
        c_idx0 = -1;
        c_idx1 = -1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [DATA_W-1:0] s, up, v0, v1;
        logic [INC_W-1:0]  inc;
        logic [CNT_W-1:0]  len;
        int c0, c1, n;

        rst_n         = 1'b0;
        rf_bist_go    = 1'b0;
        rf_bist_abort = 1'b0;
        scramble_rf();
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_state",     64'(bist_state),          64'd0);
        check("rst_gen_rst_n", 64'(gen_rst_n),           64'd0);
        check("rst_busy",      64'(bist_busy),           64'd0);
        check("rst_done",      64'(bist_done),           64'd0);
        check("rst_pass",      64'(bist_pass),           64'd0);
        check("rst_timeout",   64'(bist_timeout),        64'd0);
        check("rst_err_cnt",   64'(bist_err_cnt),        64'd0);
        check("rst_first_err", 64'(bist_first_err_data), 64'd0);
        check("rst_start_val", 64'(gen_start_val),       64'd0);
        check("rst_inc",       64'(gen_inc),             64'd0);
        check("rst_up_limit",  64'(gen_up_limit),        64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean saw-tooth 0,1,2,3,0,1,2,3
        run_test("t1_clean", 32'd0, 8'd1, 32'd3, 16'd8, -1, 32'd0, -1, 32'd0, 1'b0, 1'b0, 1'b0);
        // Word 5 corrupted
        run_test("t2_corrupt", 32'd0, 8'd1, 32'd3, 16'd8, 5, 32'hDEAD, -1, 32'd0, 1'b0, 1'b0, 1'b0);
        // Wrap through zero without hitting the limit
        run_test("t5_wrap", 32'hFFFF_FFF0, 8'h20, 32'hFFFF_FFFF, 16'd3,
                 -1, 32'd0, -1, 32'd0, 1'b0, 1'b0, 1'b0);
        // Stray rx_xfc during ARM must not count
        run_test("t_inj_arm", 32'd100, 8'd7, 32'd140, 16'd10, -1, 32'd0, -1, 32'd0, 1'b1, 1'b0, 1'b0);

        // Randomized runs
        for (int t = 0; t < 10; t++) begin
            s   = $urandom;
            inc = INC_W'($urandom);
            up  = ($urandom_range(0, 7) == 0) ? s - 32'd5 : s + 32'($urandom_range(0, 300));
            len = CNT_W'($urandom_range(1, 30));
            c0  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, int'(len) - 1)) : -1;
            c1  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, int'(len) - 1)) : -1;
            v0  = $urandom;
            v1  = $urandom;
            run_test("rand_run", s, inc, up, len, c0, v0, c1, v1,
                     1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end

        // Timeout: words stop after two of four
        run_test("t3_timeout", 32'd0, 8'd1, 32'd3, 16'd4, -1, 32'd0, -1, 32'd0, 1'b0, 1'b0, 1'b1);

        // Abort during RUN after word 1 was corrupted
        c_idx0 = 1; c_val0 = 32'h0000_0BAD;
        sck_en = 1'b1;
        pulse_go(32'd0, 8'd1, 32'd3, 16'd8, 1'b0, 1'b0);
        n = 0;
        while (g_idx < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_word3", 64'(g_idx >= 3), 64'd1);
        rf_bist_abort = 1'b1;
        sck_force     = 1'b1;
        @(negedge clk);
        rf_bist_abort = 1'b0;
        check("abort_state",     64'(bist_state),          64'd0);
        check("abort_busy",      64'(bist_busy),           64'd0);
        check("abort_done",      64'(bist_done),           64'd0);
        check("abort_pass",      64'(bist_pass),           64'd0);
        check("abort_gen_rst_n", 64'(gen_rst_n),           64'd0);
        check("abort_gen_sck",   64'(gen_sck_transition),  64'd0);
        check("abort_err_kept",  64'(bist_err_cnt),        64'd1);
        check("abort_first_err", 64'(bist_first_err_data), 64'h0000_0BAD);
        sck_force = 1'b0;
        sck_en    = 1'b0;
        c_idx0    = -1;
        repeat (3) @(negedge clk);

        // go and abort together in IDLE: nothing starts
        pulse_go(32'd0, 8'd1, 32'd3, 16'd8, 1'b0, 1'b1);
        check("goabort_state", 64'(bist_state), 64'd0);
        check("goabort_busy",  64'(bist_busy),  64'd0);
        check("goabort_done",  64'(bist_done),  64'd0);
        repeat (2) @(negedge clk);

        // Zero-length run: immediate pass, generator never released
        exp_q.push_back({1'b0, 1'b1, CNT_W'(0), DATA_W'(0)});
        pulse_go(32'd55, 8'd3, 32'd99, 16'd0, 1'b0, 1'b0);
        check("len0_busy", 64'(bist_busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            check("len0_gen_rst_n", 64'(gen_rst_n), 64'd0);
            @(negedge clk);
        end
        wait_drain("t6_len0");

        // Abort in DONE has no effect
        pulse_abort();
        check("done_abort_state", 64'(bist_state), 64'd3);
        check("done_abort_done",  64'(bist_done),  64'd1);
        check("done_abort_pass",  64'(bist_pass),  64'd1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
